// File: rtl/cache_port_arbiter.sv
// Two-port arbiter in front of a single cache controller: port 0 is instruction
// fetch (read-only), port 1 is data load/store. Round-robin grant, watchdog abort.
module cache_port_arbiter #(
  parameter int memory_bits = 5,
  parameter int data_width  = 8,
  parameter int timeout     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_read,
  input  logic [memory_bits-1:0] req0_addr,
  input  logic                   req1_read,
  input  logic                   req1_write,
  input  logic [memory_bits-1:0] req1_addr,
  input  logic [data_width-1:0]  req1_wdata,
  output logic                   ack0,
  output logic                   ack1,
  output logic [data_width-1:0]  rdata,
  output logic                   err,
  output logic                   cache_read,
  output logic                   cache_write,
  output logic [memory_bits-1:0] cache_addr,
  output logic [data_width-1:0]  cache_wdata,
  input  logic                   cache_done,
  input  logic [data_width-1:0]  cache_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(timeout - 1);

  state_t                 r_state;
  logic                   r_lastGrant;
  logic                   r_grant;
  logic                   r_isWrite;
  logic [1:0]             r_mask;
  logic [7:0]             r_timer;
  logic [memory_bits-1:0] r_addr;
  logic [data_width-1:0]  r_wdata;
  logic [data_width-1:0]  r_rdata;
  logic                   r_ack0;
  logic                   r_ack1;
  logic                   r_err;
  logic                   r_cacheRead;
  logic                   r_cacheWrite;

  logic w_p0;
  logic w_p1;
  logic w_pick1;
  logic w_pickWrite;

  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign w_p0        = req0_read & ~r_mask[0];
  assign w_p1        = (req1_read | req1_write) & ~r_mask[1];
  assign w_pick1     = w_p1 & (~w_p0 | ~r_lastGrant);
  assign w_pickWrite = w_pick1 & req1_write & ~req1_read;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_lastGrant  <= 1'b1;
      r_grant      <= 1'b0;
      r_isWrite    <= 1'b0;
      r_mask       <= 2'b00;
      r_timer      <= 8'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err        <= 1'b0;
      r_cacheRead  <= 1'b0;
      r_cacheWrite <= 1'b0;
    end else begin
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_cacheRead  <= 1'b0;
      r_cacheWrite <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mask <= 2'b00;
          if (w_p0 || w_p1) begin
            r_grant      <= w_pick1;
            r_isWrite    <= w_pickWrite;
            r_addr       <= w_pick1 ? req1_addr : req0_addr;
            if (w_pick1) r_wdata <= req1_wdata;
            r_cacheRead  <= ~w_pickWrite;
            r_cacheWrite <= w_pickWrite;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_timer <= 8'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over the watchdog on the same cycle.
          if (cache_done) begin
            r_rdata <= r_isWrite ? '0 : cache_rdata;
            r_err   <= 1'b0;
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_state <= RESP;
          end else if (r_timer == TIMER_LAST) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_state <= RESP;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        RESP: begin
          r_lastGrant <= r_grant;
          r_mask      <= r_grant ? 2'b10 : 2'b01;
          r_err       <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata       = r_rdata;
  assign err         = r_err;
  assign cache_read  = r_cacheRead;
  assign cache_write = r_cacheWrite;
  assign cache_addr  = r_addr;
  assign cache_wdata = r_wdata;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a per-cycle vector table followed by
// hand-written reset, round-robin and watchdog sequences.
module tb_cache_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0Read;
  logic [4:0] req0Addr;
  logic       req1Read;
  logic       req1Write;
  logic [4:0] req1Addr;
  logic [7:0] req1Wdata;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata;
  logic       err;
  logic       cacheRead;
  logic       cacheWrite;
  logic [4:0] cacheAddr;
  logic [7:0] cacheWdata;
  logic       cacheDone;
  logic [7:0] cacheRdata;

  int nCompared   = 0;
  int nMismatched = 0;

  cache_port_arbiter #(.memory_bits(5), .data_width(8), .timeout(16)) dut (
    .clk(clk), .reset(reset),
    .req0_read(req0Read), .req0_addr(req0Addr),
    .req1_read(req1Read), .req1_write(req1Write),
    .req1_addr(req1Addr), .req1_wdata(req1Wdata),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .cache_read(cacheRead), .cache_write(cacheWrite),
    .cache_addr(cacheAddr), .cache_wdata(cacheWdata),
    .cache_done(cacheDone), .cache_rdata(cacheRdata)
  );

  always #5 clk = ~clk;

  // eCtl packs {ack0, ack1, err, cache_read, cache_write} seen after the edge.
  typedef struct {
    logic       rstN;
    logic       r0;
    logic [4:0] a0;
    logic       r1r;
    logic       r1w;
    logic [4:0] a1;
    logic [7:0] wd;
    logic       done;
    logic [7:0] crd;
    logic [4:0] eCtl;
    logic [4:0] eAddr;
    logic       chkW;
    logic [7:0] eWd;
    logic [7:0] eRd;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic rstN, logic r0, logic [4:0] a0, logic r1r, logic r1w,
                              logic [4:0] a1, logic [7:0] wd, logic done, logic [7:0] crd,
                              logic [4:0] eCtl, logic [4:0] eAddr, logic chkW,
                              logic [7:0] eWd, logic [7:0] eRd);
    vec_t v;
    v.rstN = rstN; v.r0 = r0; v.a0 = a0; v.r1r = r1r; v.r1w = r1w; v.a1 = a1;
    v.wd = wd; v.done = done; v.crd = crd; v.eCtl = eCtl; v.eAddr = eAddr;
    v.chkW = chkW; v.eWd = eWd; v.eRd = eRd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset      = v.rstN;
    req0Read   = v.r0;
    req0Addr   = v.a0;
    req1Read   = v.r1r;
    req1Write  = v.r1w;
    req1Addr   = v.a1;
    req1Wdata  = v.wd;
    cacheDone  = v.done;
    cacheRdata = v.crd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] eA;
    reset = 1'b0; req0Read = 0; req0Addr = 0; req1Read = 0; req1Write = 0;
    req1Addr = 0; req1Wdata = 0; cacheDone = 0; cacheRdata = 0;

    //           rstN r0 a0     r1r r1w a1     wd     dn crd    eCtl      eAddr  chkW eWd    eRd
    vecs[0]  = mk(0, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h00, 1, 8'h00, 8'h00);
    vecs[1]  = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h00, 1, 8'h00, 8'h00);
    vecs[2]  = mk(1, 1, 5'h0A, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00010, 5'h0A, 1, 8'h00, 8'h00);
    vecs[3]  = mk(1, 1, 5'h0A, 0, 0, 5'h00, 8'h00, 1, 8'hFF, 5'b00000, 5'h0A, 1, 8'h00, 8'h00);
    vecs[4]  = mk(1, 1, 5'h0A, 0, 0, 5'h00, 8'h00, 1, 8'h3C, 5'b10000, 5'h0A, 1, 8'h00, 8'h3C);
    vecs[5]  = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h0A, 1, 8'h00, 8'h00);
    vecs[6]  = mk(1, 0, 5'h00, 0, 1, 5'h13, 8'hA5, 0, 8'h00, 5'b00001, 5'h13, 1, 8'hA5, 8'h00);
    vecs[7]  = mk(1, 0, 5'h00, 0, 1, 5'h13, 8'hA5, 0, 8'h00, 5'b00000, 5'h13, 1, 8'hA5, 8'h00);
    vecs[8]  = mk(1, 0, 5'h00, 0, 1, 5'h13, 8'hA5, 0, 8'h00, 5'b00000, 5'h13, 1, 8'hA5, 8'h00);
    vecs[9]  = mk(1, 0, 5'h00, 0, 1, 5'h13, 8'hA5, 0, 8'h00, 5'b00000, 5'h13, 1, 8'hA5, 8'h00);
    vecs[10] = mk(1, 0, 5'h00, 0, 1, 5'h13, 8'hA5, 0, 8'h00, 5'b00000, 5'h13, 1, 8'hA5, 8'h00);
    vecs[11] = mk(1, 0, 5'h00, 0, 1, 5'h13, 8'hA5, 1, 8'h00, 5'b01000, 5'h13, 1, 8'hA5, 8'h00);
    vecs[12] = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h13, 1, 8'hA5, 8'h00);
    vecs[13] = mk(1, 1, 5'h04, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00010, 5'h04, 0, 8'h00, 8'h00);
    vecs[14] = mk(1, 1, 5'h04, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h04, 0, 8'h00, 8'h00);
    vecs[15] = mk(1, 1, 5'h04, 0, 0, 5'h00, 8'h00, 1, 8'h5A, 5'b10000, 5'h04, 0, 8'h00, 8'h5A);
    vecs[16] = mk(1, 1, 5'h04, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h04, 0, 8'h00, 8'h00);
    vecs[17] = mk(1, 1, 5'h04, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h04, 0, 8'h00, 8'h00);
    vecs[18] = mk(1, 1, 5'h04, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00010, 5'h04, 0, 8'h00, 8'h00);
    vecs[19] = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h04, 0, 8'h00, 8'h00);
    vecs[20] = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 1, 8'hC3, 5'b10000, 5'h04, 0, 8'h00, 8'hC3);
    vecs[21] = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h04, 0, 8'h00, 8'h00);
    vecs[22] = mk(1, 0, 5'h00, 1, 1, 5'h07, 8'h99, 0, 8'h00, 5'b00010, 5'h07, 1, 8'h99, 8'h00);
    vecs[23] = mk(1, 0, 5'h00, 1, 1, 5'h07, 8'h99, 0, 8'h00, 5'b00000, 5'h07, 1, 8'h99, 8'h00);
    vecs[24] = mk(1, 0, 5'h00, 1, 1, 5'h07, 8'h99, 1, 8'h6D, 5'b01000, 5'h07, 1, 8'h99, 8'h6D);
    vecs[25] = mk(1, 0, 5'h00, 0, 0, 5'h00, 8'h00, 0, 8'h00, 5'b00000, 5'h07, 1, 8'h99, 8'h00);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d ctl", i), 32'({ack0, ack1, err, cacheRead, cacheWrite}), 32'(vecs[i].eCtl));
      checkOutput($sformatf("vec%0d addr", i), 32'(cacheAddr), 32'(vecs[i].eAddr));
      if (vecs[i].chkW) checkOutput($sformatf("vec%0d wdata", i), 32'(cacheWdata), 32'(vecs[i].eWd));
      if (vecs[i].eCtl[4] || vecs[i].eCtl[3])
        checkOutput($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].eRd));
    end

    // Reset while a port 1 write sits in WAIT: abandoned, no ack afterwards.
    reset = 1'b0; tick(); reset = 1'b1;
    req1Write = 1; req1Addr = 5'h1F; req1Wdata = 8'hEE; cacheDone = 0;
    tick();
    checkOutput("rst issue strobe", 32'({cacheWrite, cacheAddr}), 32'({1'b1, 5'h1F}));
    tick(); tick();
    reset = 1'b0; req1Write = 0;
    tick();
    checkOutput("rst midwait outputs", 32'({ack1, cacheWrite, cacheAddr, cacheWdata}), 32'(0));
    reset = 1'b1; cacheDone = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rst no ack c%0d", i), 32'({ack0, ack1, cacheRead, cacheWrite}), 32'(0));
    end
    cacheDone = 0;

    // Both ports hold requests with immediate completion: grants alternate 0,1,0,1.
    reset = 1'b0; tick(); reset = 1'b1;
    req0Read = 1; req0Addr = 5'h01; req1Read = 1; req1Addr = 5'h02;
    cacheDone = 1; cacheRdata = 8'h11;
    for (int i = 0; i < 16; i++) begin
      tick();
      eA = ((i % 8) < 4) ? 5'h01 : 5'h02;
      checkOutput($sformatf("rr c%0d", i), 32'({ack0, ack1, cacheRead, cacheAddr}),
                  32'({((i % 8) == 2), ((i % 8) == 6), ((i % 4) == 0), eA}));
      if (((i % 8) == 2) || ((i % 8) == 6)) checkOutput($sformatf("rr rdata c%0d", i), 32'(rdata), 32'h11);
    end
    req0Read = 0; req1Read = 0; cacheDone = 0;
    tick();

    // Controller never completes: 16 WAIT cycles, then ack0 with err and zero data.
    req0Read = 1; req0Addr = 5'h09; cacheRdata = 8'hAB;
    for (int i = 0; i < 18; i++) begin
      tick();
      checkOutput($sformatf("tmo c%0d", i), 32'({ack0, err, cacheRead}), 32'({(i == 17), (i == 17), (i == 0)}));
      if (i == 17) checkOutput("tmo rdata", 32'(rdata), 32'(0));
    end
    req0Read = 0;
    tick(); tick();
    req0Read = 1; req0Addr = 5'h0C;
    tick();
    checkOutput("post tmo issue", 32'({cacheRead, cacheAddr}), 32'({1'b1, 5'h0C}));
    tick();
    cacheDone = 1; cacheRdata = 8'h42;
    tick();
    checkOutput("post tmo ack", 32'({ack0, err, rdata}), 32'({1'b1, 1'b0, 8'h42}));
    req0Read = 0; cacheDone = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
